// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared types and constants for the PS/2 set-2 scancode decoder.
package ps2_scancode_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BREAK,
    EXT_BREAK,
    PAUSE
  } ps2_decode_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PS2_PREFIX_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_PAUSE_CODE   = 8'h77;
  localparam logic [2:0] PS2_PAUSE_SKIP   = 3'd7;

  typedef struct packed {
    logic       extended;
    logic       is_release;
    logic [7:0] code;
  } ps2_key_event_t;

  // Keyboard status/ack bytes that never belong to a key sequence.
  function automatic logic ps2_is_filler(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
           (b == 8'hFE) || (b == 8'hFF);
  endfunction

  function automatic logic ps2_is_fake_shift(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to key-event decoder with modifier tracking.
// Optional sequence timeout enabled by defining PS2_DECODER_TIMEOUT_EN.
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [7:0] event_code,
  output logic       event_extended,
  output logic       event_release,
  output logic [2:0] modifiers,
  output logic       overflow
);

  ps2_decode_state_t state_q, state_d, cur_state;
  logic [2:0]        skip_q, skip_d;
  ps2_key_event_t    event_q, new_event;
  logic              event_valid_q;
  logic              overflow_q;
  logic [5:0]        held_q;
  logic              emit;
  logic              expired;

`ifdef PS2_DECODER_TIMEOUT_EN
  localparam int TimerW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TimerW-1:0] timer_q;

  assign expired = (timer_q == TimerW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if (byte_valid || (state_q == IDLE) || expired) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  // An expiring sequence is treated as IDLE so a byte on that cycle starts fresh.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    emit      = 1'b0;
    new_event = '0;
    cur_state = expired ? IDLE : state_q;
    if (expired) state_d = IDLE;
    if (byte_valid) begin
      case (cur_state)
        IDLE: begin
          if (byte_data == PS2_PREFIX_EXT) begin
            state_d = EXT;
          end else if (byte_data == PS2_PREFIX_BREAK) begin
            state_d = BREAK;
          end else if (byte_data == PS2_PREFIX_PAUSE) begin
            state_d = PAUSE;
            skip_d  = PS2_PAUSE_SKIP;
          end else if (!ps2_is_filler(byte_data)) begin
            emit      = 1'b1;
            new_event = '{extended: 1'b0, is_release: 1'b0, code: byte_data};
          end
        end
        EXT: begin
          if (byte_data == PS2_PREFIX_BREAK) begin
            state_d = EXT_BREAK;
          end else begin
            state_d = IDLE;
            if (!ps2_is_fake_shift(byte_data)) begin
              emit      = 1'b1;
              new_event = '{extended: 1'b1, is_release: 1'b0, code: byte_data};
            end
          end
        end
        BREAK: begin
          state_d   = IDLE;
          emit      = 1'b1;
          new_event = '{extended: 1'b0, is_release: 1'b1, code: byte_data};
        end
        EXT_BREAK: begin
          state_d = IDLE;
          if (!ps2_is_fake_shift(byte_data)) begin
            emit      = 1'b1;
            new_event = '{extended: 1'b1, is_release: 1'b1, code: byte_data};
          end
        end
        PAUSE: begin
          skip_d = (skip_q != 3'd0) ? skip_q - 3'd1 : 3'd0;
          if (skip_q <= 3'd1) begin
            state_d   = IDLE;
            emit      = 1'b1;
            new_event = '{extended: 1'b1, is_release: 1'b0, code: PS2_PAUSE_CODE};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // held_q = {r_alt, l_alt, r_ctrl, l_ctrl, r_shift, l_shift}; updated even for dropped events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      skip_q        <= 3'd0;
      event_q       <= '0;
      event_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      held_q        <= 6'd0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      overflow_q <= 1'b0;
      if (event_valid_q && event_ready) event_valid_q <= 1'b0;
      if (emit) begin
        if (!event_valid_q || event_ready) begin
          event_q       <= new_event;
          event_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
        if (!new_event.extended) begin
          case (new_event.code)
            8'h12:   held_q[0] <= !new_event.is_release;
            8'h59:   held_q[1] <= !new_event.is_release;
            8'h14:   held_q[2] <= !new_event.is_release;
            8'h11:   held_q[4] <= !new_event.is_release;
            default: ;
          endcase
        end else begin
          case (new_event.code)
            8'h14:   held_q[3] <= !new_event.is_release;
            8'h11:   held_q[5] <= !new_event.is_release;
            default: ;
          endcase
        end
      end
    end
  end

  assign event_valid    = event_valid_q;
  assign event_code     = event_q.code;
  assign event_extended = event_q.extended;
  assign event_release  = event_q.is_release;
  assign overflow       = overflow_q;
  assign modifiers      = {held_q[5] | held_q[4], held_q[3] | held_q[2], held_q[1] | held_q[0]};

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder.
// Timeout cases run only when PS2_DECODER_TIMEOUT_EN is defined.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       event_ready = 1'b1;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_extended;
  logic       event_release;
  logic [2:0] modifiers;
  logic       overflow;

  int checkCount = 0;
  int errorCount = 0;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_code     (event_code),
    .event_extended (event_extended),
    .event_release  (event_release),
    .modifiers      (modifiers),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; presents one byte for one cycle and returns at the next falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic checkEvent(input string tag, input logic [7:0] code, input logic ext, input logic rel);
    checkOutput({tag, ".valid"}, 32'(event_valid), 32'd1);
    checkOutput({tag, ".code"}, 32'(event_code), 32'(code));
    checkOutput({tag, ".ext"}, 32'(event_extended), 32'(ext));
    checkOutput({tag, ".rel"}, 32'(event_release), 32'(rel));
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] pauseSeq [8];
    pauseSeq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    repeat (2) @(negedge clk);
    checkOutput("rst.valid", 32'(event_valid), 32'd0);
    checkOutput("rst.code", 32'(event_code), 32'd0);
    checkOutput("rst.ext", 32'(event_extended), 32'd0);
    checkOutput("rst.rel", 32'(event_release), 32'd0);
    checkOutput("rst.mods", 32'(modifiers), 32'd0);
    checkOutput("rst.ovf", 32'(overflow), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(8'h1C);
    checkEvent("make1C", 8'h1C, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("accepted.valid", 32'(event_valid), 32'd0);

    applyStimulus(8'hF0);
    checkOutput("F0.novalid", 32'(event_valid), 32'd0);
    applyStimulus(8'h1C);
    checkEvent("break1C", 8'h1C, 1'b0, 1'b1);

    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h74);
    checkEvent("extbreak74", 8'h74, 1'b1, 1'b1);

    applyStimulus(8'hE0);
    applyStimulus(8'h12);
    checkOutput("fakeshift.valid", 32'(event_valid), 32'd0);
    applyStimulus(8'hE0);
    applyStimulus(8'h74);
    checkEvent("extmake74", 8'h74, 1'b1, 1'b0);
    checkOutput("fakeshift.mods", 32'(modifiers), 32'd0);

    applyStimulus(8'hAA);
    checkOutput("filler.valid", 32'(event_valid), 32'd0);

    applyStimulus(8'h12);
    checkOutput("mods.lshift", 32'(modifiers), 32'b001);
    applyStimulus(8'h14);
    checkOutput("mods.lctrl", 32'(modifiers), 32'b011);
    applyStimulus(8'hE0);
    applyStimulus(8'h11);
    checkOutput("mods.ralt", 32'(modifiers), 32'b111);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    checkOutput("mods.relshift", 32'(modifiers), 32'b110);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h11);
    checkOutput("mods.relralt", 32'(modifiers), 32'b010);
    applyStimulus(8'hF0);
    applyStimulus(8'h14);
    checkOutput("mods.clear", 32'(modifiers), 32'b000);
    @(negedge clk);

    event_ready = 1'b0;
    applyStimulus(8'h1C);
    checkEvent("hold1C", 8'h1C, 1'b0, 1'b0);
    checkOutput("hold.noovf", 32'(overflow), 32'd0);
    applyStimulus(8'h12);
    checkOutput("drop.ovf", 32'(overflow), 32'd1);
    checkEvent("drop.kept", 8'h1C, 1'b0, 1'b0);
    checkOutput("drop.mods", 32'(modifiers), 32'b001);
    @(negedge clk);
    checkOutput("drop.ovfonce", 32'(overflow), 32'd0);
    applyStimulus(8'hF0);
    event_ready = 1'b1;
    applyStimulus(8'h12);
    checkEvent("reload", 8'h12, 1'b0, 1'b1);
    checkOutput("reload.noovf", 32'(overflow), 32'd0);
    checkOutput("reload.mods", 32'(modifiers), 32'b000);
    @(negedge clk);
    checkOutput("reload.drain", 32'(event_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(pauseSeq[i]);
      checkOutput($sformatf("pause.valid%0d", i), 32'(event_valid), (i == 7) ? 32'd1 : 32'd0);
    end
    checkEvent("pause", 8'h77, 1'b1, 1'b0);
    checkOutput("pause.mods", 32'(modifiers), 32'd0);
    applyStimulus(8'h1C);
    checkEvent("afterpause", 8'h1C, 1'b0, 1'b0);

    applyStimulus(8'hF0);
    pulseReset();
    checkOutput("midrst.valid", 32'(event_valid), 32'd0);
    applyStimulus(8'h1C);
    checkEvent("midrst.make", 8'h1C, 1'b0, 1'b0);

`ifdef PS2_DECODER_TIMEOUT_EN
    applyStimulus(8'hE0);
    repeat (15) @(negedge clk);
    applyStimulus(8'h1C);
    checkEvent("to.before", 8'h1C, 1'b1, 1'b0);
    applyStimulus(8'hE0);
    repeat (16) @(negedge clk);
    applyStimulus(8'h1C);
    checkEvent("to.expired", 8'h1C, 1'b0, 1'b0);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Converts the raw PS/2 set-2 byte stream from the PS/2 receive path into single-word key events (make/break, extended flag, 8-bit code) and tracks modifier key state. Sits directly downstream of the PS/2 byte receiver, consuming its one-cycle byte strobe, and presents events to the keyboard peripheral's event queue through a valid/ready handshake.

## Interface
- TIMEOUT_CYCLES, 1000000: idle cycles after which a partially received multi-byte sequence is abandoned.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- byte_valid  input  1  one-cycle strobe; byte_data is a newly received byte.
- byte_data  input  8  received scancode byte.
- event_valid  output  1  an event is held on event_*.
- event_ready  input  1  consumer accepts the event when high with event_valid.
- event_code  output  8  base scancode.
- event_extended  output  1  sequence began with 0xE0 (or is the pause key).
- event_release  output  1  1 = break (key up), 0 = make (key down).
- modifiers  output  3  {alt, ctrl, shift}, level, any side held.
- overflow  output  1  one-cycle pulse when a completed event is dropped.

## Operation
- States: IDLE, EXT (after E0), BREAK (after F0), EXT_BREAK (after E0 F0), PAUSE (skipping pause sequence).
- IDLE: E0→EXT; F0→BREAK; E1→PAUSE, skip counter=7; 0x00, 0xAA, 0xFA, 0xFE, 0xFF ignored; any other byte→emit make (ext=0), stay IDLE.
- EXT: F0→EXT_BREAK; 0x12 or 0x59 (fake shift) discarded→IDLE; other→emit make (ext=1)→IDLE.
- BREAK: any byte→emit break (ext=0)→IDLE. EXT_BREAK: 0x12/0x59 discarded; other→emit break (ext=1)→IDLE.
- PAUSE: each byte decrements counter; at 0→emit make, code 0x77, ext=1→IDLE. No break event for pause.
- Emit: if output register empty or accepted in the same cycle (event_valid && event_ready), load event and assert event_valid; otherwise drop new event, pulse overflow, state still advances.
- event_valid/event_* hold stable until event_ready; event_valid deasserts the cycle after acceptance unless a new event loads.
- Modifiers update on every emitted or dropped event: shift=L(0x12)|R(0x59); ctrl=L(0x14)|R(E0 14); alt=L(0x11)|R(E0 11). Four/six internal held bits; make sets, break clears.
- Bytes arriving while not byte_valid ignored; byte_valid never back-pressured.

## Timing
- Reset: state=IDLE, event_valid=0, event_code=0, event_extended=0, event_release=0, modifiers=0, overflow=0, timeout counter=0, skip counter=0.
- Latency: event_valid rises the cycle after byte_valid of the sequence's final byte; modifiers update same edge.
- Simultaneous accept and new emit: register reloads, event_valid stays high, no overflow.
- Reset mid-sequence: returns to IDLE; partial sequence lost.
- Skip counter 3 bits, no wrap (only counts 7→0).

## Configuration
- PS2_DECODER_TIMEOUT_EN defined: counter ($clog2(TIMEOUT_CYCLES+1) bits) clears on byte_valid or in IDLE, increments otherwise; reaching TIMEOUT_CYCLES forces IDLE with no event and clears to 0. byte_valid on the expiry cycle is decoded from IDLE.
- Undefined: no counter; non-IDLE states wait indefinitely; TIMEOUT_CYCLES unused.

## Structure
- Shared package defines: ps2_decode_state_t enum; constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BREAK=8'hF0, PS2_PREFIX_PAUSE=8'hE1; ps2_key_event_t struct {extended, release, code}.
- Single module; no sub-module. Modifier tracking and output register inline.

## Test plan
- Bytes 1C → event code=1C, ext=0, release=0, one cycle after strobe; F0 1C → release=1.
- E0 F0 74 with event_ready=1 → code=74, ext=1, release=1; E0 12 E0 74 → only one event (74, ext=1), shift stays 0.
- 12 then 14 then E0 11 → modifiers=3'b111; F0 12 → 3'b110; E0 F0 11 → 3'b010.
- event_ready=0, send 1C then 32 → first event held (1C), overflow pulses once, 32 lost; raise ready same cycle as a new emit → reload, no overflow.
- E1 14 77 E1 F0 14 F0 77 → exactly one event code=77, ext=1, release=0; following 1C decodes normally.
- With PS2_DECODER_TIMEOUT_EN, TIMEOUT_CYCLES=16: send E0, wait 16 cycles, send 1C → ext=0; assert reset (low) after F0 → next 1C is make.
